// File: rtl/quant_sched.sv
// quant_sched: block scheduler for the JPEG quantization stage.
// Accepts 8x8 blocks from the DCT, walks each 4:2:0 MCU as Y0..Y3, Cb, Cr.
// Every block gets one 16-cycle table window followed by a 1-cycle gap.
// MCUs are counted until the latched frame total is reached.
module quant_sched #(
  parameter int MCU_W = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic [MCU_W-1:0] mcu_total,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             zz_free,
  output logic             enable_quant,
  output logic             enable_y,
  output logic             enable_cb,
  output logic             enable_cr,
  output logic             rows_active,
  output logic [2:0]       blk_idx,
  output logic [MCU_W-1:0] mcu_cnt,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_QUANT = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       win_q, win_d;
  logic [2:0]       blk_idx_q, blk_idx_d;
  logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic [MCU_W-1:0] total_q, total_d;
  logic [MCU_W-1:0] mcu_cnt_inc_s;

  // Incremented MCU count, full width; a frame never reaches the wrap point
  // because the compare against the latched total stops it first.
  assign mcu_cnt_inc_s = mcu_cnt_q + {{(MCU_W-1){1'b0}}, 1'b1};

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      win_q     <= 4'd0;
      blk_idx_q <= 3'd0;
      mcu_cnt_q <= {MCU_W{1'b0}};
      total_q   <= {MCU_W{1'b0}};
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      blk_idx_q <= blk_idx_d;
      mcu_cnt_q <= mcu_cnt_d;
      total_q   <= total_d;
    end
  end

  // Next-state logic: abort first, then the per-state walk through the MCU.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    blk_idx_d = blk_idx_q;
    mcu_cnt_d = mcu_cnt_q;
    total_d   = total_q;
    if (abort) begin
      // In IDLE an abort only suppresses a coincident start.
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        win_d     = 4'd0;
        blk_idx_d = 3'd0;
        mcu_cnt_d = {MCU_W{1'b0}};
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            total_d   = mcu_total;
            blk_idx_d = 3'd0;
            mcu_cnt_d = {MCU_W{1'b0}};
            state_d   = (mcu_total == {MCU_W{1'b0}}) ? S_DONE : S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (blk_valid && zz_free) begin
            state_d = S_QUANT;
            win_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_QUANT: begin
          if (win_q == 4'd15) begin
            state_d = S_GAP;
          end else begin
            win_d = win_q + 4'd1;
          end
        end
        S_GAP: begin
          if (blk_idx_q == 3'd5) begin
            blk_idx_d = 3'd0;
            mcu_cnt_d = mcu_cnt_inc_s;
            state_d   = (mcu_cnt_inc_s == total_q) ? S_DONE : S_WAIT;
          end else begin
            blk_idx_d = blk_idx_q + 3'd1;
            state_d   = S_WAIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Moore decode of the registered state; only blk_ready also sees zz_free.
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);
  assign blk_ready    = (state_q == S_WAIT) && zz_free;
  assign enable_quant = (state_q == S_QUANT);
  assign enable_y     = enable_quant && (blk_idx_q < 3'd4);
  assign enable_cb    = enable_quant && (blk_idx_q == 3'd4);
  assign enable_cr    = enable_quant && (blk_idx_q == 3'd5);
  assign rows_active  = enable_quant && win_q[3];
  assign blk_idx      = blk_idx_q;
  assign mcu_cnt      = mcu_cnt_q;

endmodule

// File: tb/tb_quant_sched.sv
// tb_quant_sched: directed scenarios plus randomized traffic, every cycle
// compared against a timestamp-based reference model of the scheduler.
module tb_quant_sched;

  logic        clk = 1'b0;
  logic        nrst, start, abort, blk_valid, zz_free;
  logic [11:0] mcu_total;
  logic        blk_ready, enable_quant, enable_y, enable_cb, enable_cr;
  logic        rows_active, busy, frame_done;
  logic [2:0]  blk_idx;
  logic [11:0] mcu_cnt;

  quant_sched #(.MCU_W(12)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .mcu_total(mcu_total), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .zz_free(zz_free), .enable_quant(enable_quant), .enable_y(enable_y),
    .enable_cb(enable_cb), .enable_cr(enable_cr), .rows_active(rows_active),
    .blk_idx(blk_idx), .mcu_cnt(mcu_cnt), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam int NEVER = 32'h7fffffff;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a frame is a series of acceptances; every output in a
  // cycle follows from how far that cycle is from the last acceptance.
  bit m_act = 1'b0;
  int m_total = 0, m_n = 0, m_tacc = 0, m_tready = 0;
  int m_tdone = NEVER, m_final = 0, m_first_acc = 0;

  // Observed statistics for the directed scenarios.
  int s_q, s_y, s_cb, s_cr, s_rows, s_done, s_busy, s_done_cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_word();
    return {9'd0, blk_ready, enable_quant, enable_y, enable_cb, enable_cr,
            rows_active, busy, frame_done, blk_idx, mcu_cnt};
  endfunction

  function automatic logic [31:0] exp_word();
    logic r, q, y, cb, cr, rw, bs, dn;
    logic [2:0]  ix;
    logic [11:0] ct;
    int d, b;
    {r, q, y, cb, cr, rw, bs, dn} = 8'd0;
    ix = 3'd0;
    ct = 12'(m_final);
    if (m_act) begin
      bs = 1'b1;
      if (cyc == m_tdone) begin
        dn = 1'b1;
        ct = 12'(m_total);
      end else if (cyc < m_tready) begin
        d  = cyc - m_tacc;          // 1..16 window, 17 gap
        b  = (m_n - 1) % 6;
        q  = (d <= 16);
        y  = q && (b < 4);
        cb = q && (b == 4);
        cr = q && (b == 5);
        rw = q && (d >= 9);
        ix = 3'(b);
        ct = 12'((m_n - 1) / 6);
      end else begin
        r  = zz_free;
        ix = 3'(m_n % 6);
        ct = 12'(m_n / 6);
      end
    end
    return {9'd0, r, q, y, cb, cr, rw, bs, dn, ix, ct};
  endfunction

  function automatic bit m_waiting();
    return m_act && (cyc >= m_tready) && (cyc != m_tdone);
  endfunction

  task automatic model_edge();
    if (!nrst) begin
      m_act = 1'b0; m_final = 0;
    end else if (abort) begin
      if (m_act) begin m_act = 1'b0; m_final = 0; end
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1; m_total = int'(mcu_total); m_n = 0;
        m_tready = cyc + 1;
        m_tdone  = (mcu_total == 12'd0) ? cyc + 1 : NEVER;
      end
    end else if (cyc == m_tdone) begin
      m_act = 1'b0; m_final = m_total;
    end else if (cyc >= m_tready && blk_valid && zz_free) begin
      m_n++;
      if (m_n == 1) m_first_acc = cyc;
      m_tacc = cyc; m_tready = cyc + 18;
      if (m_n == 6 * m_total) m_tdone = cyc + 18;
    end
  endtask

  task automatic reset_stats();
    s_q = 0; s_y = 0; s_cb = 0; s_cr = 0; s_rows = 0;
    s_done = 0; s_busy = 0; s_done_cyc = -1;
  endtask

  // One cycle: inputs already applied; sample mid-cycle, then model the edge.
  task automatic step();
    @(negedge clk);
    check_eq("model", obs_word(), exp_word());
    s_q    += int'(enable_quant);
    s_y    += int'(enable_y);
    s_cb   += int'(enable_cb);
    s_cr   += int'(enable_cr);
    s_rows += int'(rows_active);
    s_busy += int'(busy);
    if (frame_done) begin s_done++; s_done_cyc = cyc; end
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    nrst = 1'b1; start = 1'b0; abort = 1'b0; blk_valid = 1'b1; zz_free = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (s_done != 0) break;
      step();
    end
    check_eq({tag, "_done_seen"}, 32'(s_done), 32'd1);
  endtask

  int sa, sb, da, db, stall_left;

  initial begin
    quiet();
    nrst = 1'b0;
    mcu_total = 12'd0;
    @(posedge clk);
    #1;

    // Reset with random inputs for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); abort = 1'($urandom); blk_valid = 1'($urandom);
      zz_free = 1'($urandom); mcu_total = 12'($urandom);
      nrst = 1'b0;
      step();
    end
    quiet(); zz_free = 1'b0;
    #1 check_eq("reset_outputs", obs_word(), 32'd0);

    // Single MCU, no backpressure.
    quiet(); reset_stats();
    mcu_total = 12'd1; start = 1'b1; step(); start = 1'b0;
    run_until_done("single", 300);
    check_eq("single_quant_cycles", 32'(s_q), 32'd96);
    check_eq("single_y_cycles", 32'(s_y), 32'd64);
    check_eq("single_cb_cycles", 32'(s_cb), 32'd16);
    check_eq("single_cr_cycles", 32'(s_cr), 32'd16);
    check_eq("single_rows_cycles", 32'(s_rows), 32'd48);
    check_eq("single_done_latency", 32'(s_done_cyc - m_first_acc), 32'd108);
    step();
    check_eq("single_mcu_cnt", 32'(mcu_cnt), 32'd1);

    // Two MCUs without stall as the reference timing.
    quiet(); reset_stats();
    mcu_total = 12'd2; start = 1'b1; sa = cyc; step(); start = 1'b0;
    run_until_done("nostall", 400);
    da = s_done_cyc - sa;
    check_eq("nostall_latency", 32'(da), 32'd217);
    step();

    // Two MCUs with a 20-cycle zz_free stall before the third block.
    quiet(); reset_stats(); stall_left = 20;
    mcu_total = 12'd2; start = 1'b1; sb = cyc; step(); start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (s_done != 0) break;
      zz_free = 1'b1;
      if (m_waiting() && m_n == 2 && stall_left > 0) begin
        zz_free = 1'b0;
        stall_left--;
      end
      step();
    end
    check_eq("stall_done_seen", 32'(s_done), 32'd1);
    db = s_done_cyc - sb;
    check_eq("stall_extra_cycles", 32'(db - da), 32'd20);
    check_eq("stall_quant_cycles", 32'(s_q), 32'd192);
    zz_free = 1'b1;
    step();

    // Zero-length frame.
    quiet(); reset_stats();
    mcu_total = 12'd0; start = 1'b1; sa = cyc; step(); start = 1'b0;
    run_until_done("zero", 10);
    check_eq("zero_latency", 32'(s_done_cyc - sa), 32'd1);
    step(); step();
    check_eq("zero_busy_cycles", 32'(s_busy), 32'd1);
    check_eq("zero_quant_cycles", 32'(s_q), 32'd0);

    // Abort at win 10 of block 4 in MCU 3.
    quiet(); reset_stats();
    mcu_total = 12'd5; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (m_act && m_n == 23 && cyc - m_tacc == 11) break;
      step();
    end
    check_eq("abort_reached_enable_cb", 32'(enable_cb), 32'd1);
    abort = 1'b1; step(); abort = 1'b0;
    #1 check_eq("abort_all_clear", obs_word(), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check_eq("abort_no_done", 32'(s_done), 32'd0);

    // Start ignored while busy, total changed to 7 mid-frame.
    quiet(); reset_stats();
    mcu_total = 12'd3; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 50; i++) step();
    mcu_total = 12'd7; start = 1'b1; step(); start = 1'b0;
    run_until_done("busy_start", 600);
    step();
    check_eq("busy_start_mcu_cnt", 32'(mcu_cnt), 32'd3);
    for (int i = 0; i < 30; i++) step();
    check_eq("busy_start_single_done", 32'(s_done), 32'd1);

    // Start and abort together in IDLE.
    quiet(); reset_stats();
    mcu_total = 12'd1; start = 1'b1; abort = 1'b1; step();
    start = 1'b0; abort = 1'b0;
    #1 check_eq("start_abort_idle_busy", 32'(busy), 32'd0);

    // Randomized traffic with stalls, aborts, stray starts and resets.
    for (int i = 0; i < 8000; i++) begin
      nrst      = ($urandom_range(0, 499) != 0);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 199) == 0);
      mcu_total = 12'($urandom_range(0, 2));
      blk_valid = ($urandom_range(0, 3) != 0);
      zz_free   = ($urandom_range(0, 4) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
